// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared definitions for the immediate generator pipeline.
//   - RV32/RV64 base opcode constants and shift funct3 codes
//   - fmt_e    : 3-bit immediate format code reported on out_fmt
//   - imm_result_t : one FIFO entry {imm, fmt, illegal, tag}, sized for the
//                    widest configuration (XLEN<=64, TAG_W<=TAG_MAX_W);
//                    users keep only the low XLEN / TAG_W bits.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRL = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_SH   = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  localparam int unsigned IMM_MAX_W = 64;
  localparam int unsigned TAG_MAX_W = 32;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    fmt_e                 fmt;
    logic                 illegal;
    logic [TAG_MAX_W-1:0] tag;
  } imm_result_t;

endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: purely combinational RISC-V immediate decoder.
//   inst    in  32    instruction word
//   imm     out XLEN  sign-extended (or zero-extended shamt) immediate
//   fmt     out 3     format code (imm_gen_pkg::fmt_e)
//   illegal out 1     unknown opcode, or RV32 shift with inst[25]=1
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  always_comb begin
    opcode  = inst[6:0];
    funct3  = inst[14:12];
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SRL) begin
          fmt = FMT_SH;
          if (XLEN == 64) begin
            imm = XLEN'(inst[25:20]);
          end else begin
            imm     = XLEN'(inst[24:20]);
            illegal = inst[25];
          end
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(inst[31:20]));
        end
      end
      LOAD, JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(inst[31:20]));
      end
      STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      LUI, AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OP, SYSTEM, FENCE: begin
        // no immediate, legal
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: buffered immediate generator. Decodes each accepted
// instruction combinationally and queues {imm, fmt, illegal, tag} in a
// DEPTH-entry FIFO read out on a valid/ready stream.
//   clk, reset (async, active-low), flush (sync, drops all entries)
//   in_valid/in_ready/in_inst/in_tag      : instruction stream in
//   out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag : results out
// Optional macro IMM_GEN_PIPE_STATS_EN adds saturating counters
//   stat_pushed (32) and stat_illegal (16); cleared by reset only.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PIPE_STATS_EN
  ,
  output logic [31:0]      stat_pushed,
  output logic [15:0]      stat_illegal
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  imm_result_t      mem [DEPTH];
  imm_result_t      wr_entry;
  imm_result_t      hold_q;
  imm_result_t      head;

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_illegal;
  logic             push;
  logic             pop;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_entry         = '0;
    wr_entry.imm     = IMM_MAX_W'(dec_imm);
    wr_entry.fmt     = dec_fmt;
    wr_entry.illegal = dec_illegal;
    wr_entry.tag     = TAG_MAX_W'(in_tag);
  end

  // Storage needs no reset: count gates visibility, and a write during
  // reset or flush lands in a slot that is not yet counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // hold_q keeps the last popped entry so out_* hold their value while
  // empty and read as zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    head = out_valid ? mem[rd_ptr] : hold_q;
  end

  assign out_imm     = head.imm[XLEN-1:0];
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;
  assign out_tag     = head.tag[TAG_W-1:0];

`ifdef IMM_GEN_PIPE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_pushed  <= '0;
      stat_illegal <= '0;
    end else begin
      if (push && stat_pushed != '1) begin
        stat_pushed <= stat_pushed + 1'b1;
      end
      if (push && dec_illegal && stat_illegal != '1) begin
        stat_illegal <= stat_illegal + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance of
// imm_gen_pipe (DEPTH=2, TAG_W=4) with identical stimulus and compares both
// against a queue-based reference model. Honors IMM_GEN_PIPE_STATS_EN.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [3:0]  in_tag;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [3:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [3:0]  b_out_tag;
`ifdef IMM_GEN_PIPE_STATS_EN
  logic [31:0] a_stat_pushed, b_stat_pushed;
  logic [15:0] a_stat_illegal, b_stat_illegal;
  int          m_pushed, m_ill32, m_ill64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(4)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
`ifdef IMM_GEN_PIPE_STATS_EN
    , .stat_pushed(a_stat_pushed), .stat_illegal(a_stat_illegal)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(4)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
`ifdef IMM_GEN_PIPE_STATS_EN
    , .stat_pushed(b_stat_pushed), .stat_illegal(b_stat_illegal)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  tag;
  } entry_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ref_t;

  entry_t q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  // Immediate value as a number, built field by field from the ISA tables.
  function automatic ref_t ref_dec(input logic [31:0] inst, input bit is64);
    ref_t   r;
    longint v;
    r = '0;
    v = 0;
    case (inst[6:0])
      7'h13: begin
        if (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) begin
          r.fmt = 3'd2;
          if (is64) v = longint'(inst[25:20]);
          else begin
            v     = longint'(inst[24:20]);
            r.ill = inst[25];
          end
        end else begin
          r.fmt = 3'd1;
          v     = longint'($signed(inst[31:20]));
        end
      end
      7'h03, 7'h67: begin r.fmt = 3'd1; v = longint'($signed(inst[31:20])); end
      7'h23: begin r.fmt = 3'd3; v = longint'($signed({inst[31:25], inst[11:7]})); end
      7'h63: begin
        r.fmt = 3'd4;
        v     = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) * 2;
      end
      7'h37, 7'h17: begin r.fmt = 3'd5; v = longint'($signed(inst[31:12])) * 4096; end
      7'h6F: begin
        r.fmt = 3'd6;
        v     = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) * 2;
      end
      7'h33, 7'h73, 7'h0F: ;
      default: r.ill = 1'b1;
    endcase
    r.imm = v;
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [31:0] p;
    logic [6:0]  ops [11];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};
    r = $urandom;
    p = $urandom_range(0, 11);
    if (p < 11) r[6:0] = ops[p];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_state();
    ref_t r32, r64;
    chk("in_ready32", 64'(a_in_ready), 64'(q.size() < DEPTH));
    chk("in_ready64", 64'(b_in_ready), 64'(q.size() < DEPTH));
    chk("out_valid32", 64'(a_out_valid), 64'(q.size() != 0));
    chk("out_valid64", 64'(b_out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      r32 = ref_dec(q[0].inst, 1'b0);
      r64 = ref_dec(q[0].inst, 1'b1);
      chk("imm32", 64'(a_out_imm), {32'b0, r32.imm[31:0]});
      chk("fmt32", 64'(a_out_fmt), 64'(r32.fmt));
      chk("ill32", 64'(a_out_illegal), 64'(r32.ill));
      chk("tag32", 64'(a_out_tag), 64'(q[0].tag));
      chk("imm64", b_out_imm, r64.imm);
      chk("fmt64", 64'(b_out_fmt), 64'(r64.fmt));
      chk("ill64", 64'(b_out_illegal), 64'(r64.ill));
      chk("tag64", 64'(b_out_tag), 64'(q[0].tag));
    end
`ifdef IMM_GEN_PIPE_STATS_EN
    chk("stat_pushed32", 64'(a_stat_pushed), 64'(m_pushed));
    chk("stat_pushed64", 64'(b_stat_pushed), 64'(m_pushed));
    chk("stat_illegal32", 64'(a_stat_illegal), 64'(m_ill32));
    chk("stat_illegal64", 64'(b_stat_illegal), 64'(m_ill64));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [3:0] tag,
                       input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid  = v;
    in_inst   = inst;
    in_tag    = tag;
    out_ready = rdy;
    flush     = fl;
    do_push   = v && (q.size() < DEPTH);
    do_pop    = rdy && (q.size() != 0);
    @(posedge clk);
`ifdef IMM_GEN_PIPE_STATS_EN
    if (do_push) begin
      m_pushed++;
      if (ref_dec(inst, 1'b0).ill) m_ill32++;
      if (ref_dec(inst, 1'b1).ill) m_ill64++;
    end
`endif
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{inst: inst, tag: tag});
    end
    #1;
    check_state();
  endtask

  initial begin
    logic [31:0] dir [6];
    dir = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h0010006F,
            32'h02309093, 32'hABCDE07F};
`ifdef IMM_GEN_PIPE_STATS_EN
    m_pushed = 0; m_ill32 = 0; m_ill64 = 0;
`endif
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("rst_imm32", 64'(a_out_imm), 64'd0);
    chk("rst_imm64", b_out_imm, 64'd0);
    chk("rst_fmt", 64'(a_out_fmt), 64'd0);
    chk("rst_ill", 64'(a_out_illegal), 64'd0);
    chk("rst_tag", 64'(a_out_tag), 64'd0);
    reset = 1'b1;
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // directed decodes, back-to-back with a free consumer
    for (int i = 0; i < 6; i++) cycle(1'b1, dir[i], 4'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("idle_valid", 64'(a_out_valid), 64'd0);

    // backpressure: three pushes into a two-entry FIFO, third held
    cycle(1'b1, dir[0], 4'd0, 1'b0, 1'b0);
    cycle(1'b1, dir[1], 4'd1, 1'b0, 1'b0);
    chk("full_ready", 64'(a_in_ready), 64'd0);
    cycle(1'b1, dir[2], 4'd2, 1'b0, 1'b0);
    cycle(1'b1, dir[2], 4'd2, 1'b1, 1'b0);
    cycle(1'b1, dir[2], 4'd2, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // flush with one entry queued and a simultaneous push
    cycle(1'b1, dir[3], 4'd5, 1'b0, 1'b0);
    cycle(1'b1, dir[4], 4'd6, 1'b1, 1'b1);
    chk("flush_valid", 64'(a_out_valid), 64'd0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, rand_inst(), 4'($urandom), ($urandom % 3) != 0,
            ($urandom % 25) == 0);
    end

    // asynchronous reset with entries queued
    cycle(1'b1, dir[0], 4'd7, 1'b0, 1'b0);
    cycle(1'b1, dir[1], 4'd8, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    q.delete();
`ifdef IMM_GEN_PIPE_STATS_EN
    m_pushed = 0; m_ill32 = 0; m_ill64 = 0;
`endif
    #1;
    chk("areset_valid32", 64'(a_out_valid), 64'd0);
    chk("areset_valid64", 64'(b_out_valid), 64'd0);
    chk("areset_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_state();
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom % 2) != 0, rand_inst(), 4'($urandom), ($urandom % 2) != 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
